// File: rtl/dp_arb_pkg.sv
// Shared types and constants for the dp_accelerator round-robin arbiter.
package dp_arb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 2;

  // Accelerator register map
  localparam logic [1:0] ADDR_BITREV  = 2'b00;
  localparam logic [1:0] ADDR_INC_RAW = 2'b01;
  localparam logic [1:0] ADDR_INV     = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/dp_arbiter_if.sv
// Requester-side command/response bus: masters issue commands, the arbiter accepts and responds.
interface dp_arbiter_if
  import dp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end
endmodule

// File: rtl/dp_arbiter.sv
// Round-robin arbiter serialising single-beat commands from NUM_REQ requesters
// onto one dp_accelerator register port; fixed 3-cycle accept/issue/respond sequence.
module dp_arbiter
  import dp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  dp_arbiter_if.slave       req_bus,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              acc_rd_en,
  output logic              acc_wr_en,
  output logic [DATA_W-1:0] acc_dataIn,
  input  logic [DATA_W-1:0] acc_dataOut,
  output logic              busy
);
  localparam int PTR_W = $clog2(NUM_REQ);

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic                cmd_wr_reg, cmd_wr_next;
  logic [ADDR_W-1:0]   cmd_addr_reg, cmd_addr_next;
  logic [DATA_W-1:0]   cmd_wdata_reg, cmd_wdata_next;
  logic [PTR_W-1:0]    cmd_id_reg, cmd_id_next;
  logic                acc_rd_en_reg, acc_rd_en_next;
  logic                acc_wr_en_reg, acc_wr_en_next;
  logic [NUM_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    winner;
  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req    (req_bus.req_valid),
    .rr_ptr (rr_ptr_reg),
    .grant  (grant),
    .winner (winner)
  );

  // Gated by reset so a requester never sees an accept that the reset would discard.
  assign req_bus.req_ready = (state_reg == IDLE && !reset) ? grant : '0;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    cmd_wr_next    = cmd_wr_reg;
    cmd_addr_next  = cmd_addr_reg;
    cmd_wdata_next = cmd_wdata_reg;
    cmd_id_next    = cmd_id_reg;
    acc_rd_en_next = 1'b0;
    acc_wr_en_next = 1'b0;
    rsp_valid_next = '0;
    rsp_rdata_next = rsp_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (|req_bus.req_valid) begin
          cmd_wr_next    = req_bus.req_wr[winner];
          cmd_addr_next  = addr_arr[winner];
          cmd_wdata_next = wdata_arr[winner];
          cmd_id_next    = winner;
          acc_wr_en_next = req_bus.req_wr[winner];
          acc_rd_en_next = !req_bus.req_wr[winner];
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        rsp_rdata_next             = cmd_wr_reg ? '0 : acc_dataOut;
        rsp_valid_next[cmd_id_reg] = 1'b1;
        state_next                 = RESP;
      end
      RESP: begin
        rr_ptr_next = (cmd_id_reg == PTR_W'(NUM_REQ-1)) ? '0 : cmd_id_reg + PTR_W'(1);
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      cmd_wr_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
      cmd_id_reg    <= '0;
      acc_rd_en_reg <= 1'b0;
      acc_wr_en_reg <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      cmd_wr_reg    <= cmd_wr_next;
      cmd_addr_reg  <= cmd_addr_next;
      cmd_wdata_reg <= cmd_wdata_next;
      cmd_id_reg    <= cmd_id_next;
      acc_rd_en_reg <= acc_rd_en_next;
      acc_wr_en_reg <= acc_wr_en_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  assign acc_addr          = cmd_addr_reg;
  assign acc_dataIn        = cmd_wdata_reg;
  assign acc_rd_en         = acc_rd_en_reg;
  assign acc_wr_en         = acc_wr_en_reg;
  assign req_bus.rsp_valid = rsp_valid_reg;
  assign req_bus.rsp_rdata = rsp_rdata_reg;
  assign busy              = (state_reg != IDLE);
endmodule

// File: tb/tb_dp_arbiter.sv
// Scoreboard bench for dp_arbiter with four requesters and a behavioural accelerator stub.
module tb_dp_arbiter;
  import dp_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dp_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  logic [AW-1:0] acc_addr;
  logic          acc_rd_en, acc_wr_en;
  logic [DW-1:0] acc_dataIn, acc_dataOut;
  logic          busy;

  dp_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_bus     (bus.slave),
    .acc_addr    (acc_addr),
    .acc_rd_en   (acc_rd_en),
    .acc_wr_en   (acc_wr_en),
    .acc_dataIn  (acc_dataIn),
    .acc_dataOut (acc_dataOut),
    .busy        (busy)
  );

  function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
    return r;
  endfunction

  // Accelerator stub: addr0 write loads, addr1 write increments; reads bitrev/raw/inverse/zero.
  logic [DW-1:0] acc_reg = '0;
  always @(posedge clock) begin
    if (acc_wr_en) begin
      if (acc_addr == ADDR_BITREV) acc_reg <= acc_dataIn;
      else if (acc_addr == ADDR_INC_RAW) acc_reg <= acc_reg + 1;
    end
  end
  always_comb begin
    acc_dataOut = '0;
    if (acc_rd_en) begin
      case (acc_addr)
        ADDR_BITREV:  acc_dataOut = bitrev(acc_reg);
        ADDR_INC_RAW: acc_dataOut = acc_reg;
        ADDR_INV:     acc_dataOut = ~acc_reg;
        default:      acc_dataOut = '0;
      endcase
    end
  end

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {int id; logic [DW-1:0] rdata; int due;} rsp_t;
  typedef struct {logic [AW-1:0] addr; bit wr; logic [DW-1:0] wdata; int due;} acc_t;
  rsp_t rsp_q[$];
  acc_t acc_q[$];

  // Reference model state
  int            m_ptr  = 0;
  int            m_free = 0;
  int            m_last = -100;
  logic [DW-1:0] m_reg  = '0;
  bit            armed  = 0;
  logic [DW-1:0] last_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // Predictor: decides who should be granted this cycle and queues the expected outcome.
  always begin
    logic [N-1:0]  exp_ready;
    int            win;
    int            j;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data, exp_rd;
    @(negedge clock);
    #1;
    if (armed) begin
      exp_ready = '0;
      win       = -1;
      if (!reset && cycle >= m_free && |bus.req_valid) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (win < 0 && bus.req_valid[j]) win = j;
        end
        exp_ready[win] = 1'b1;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(cycle == m_last + 1 || cycle == m_last + 2));
      if (win >= 0) begin
        wr   = bus.req_wr[win];
        addr = bus.req_addr[win*AW +: AW];
        data = bus.req_wdata[win*DW +: DW];
        exp_rd = '0;
        if (wr) begin
          if (addr == 2'd0) m_reg = data;
          else if (addr == 2'd1) m_reg = m_reg + 1;
        end else begin
          case (addr)
            2'd0:    exp_rd = bitrev(m_reg);
            2'd1:    exp_rd = m_reg;
            2'd2:    exp_rd = ~m_reg;
            default: exp_rd = '0;
          endcase
        end
        rsp_q.push_back('{id: win, rdata: exp_rd, due: cycle + 2});
        acc_q.push_back('{addr: addr, wr: wr, wdata: data, due: cycle + 1});
        m_ptr  = (win + 1) % N;
        m_free = cycle + 3;
        m_last = cycle;
      end
    end
    if (reset) begin
      rsp_q.delete();
      acc_q.delete();
      m_ptr  = 0;
      m_free = cycle + 1;
      m_last = -100;
      armed  = 1;
    end
  end

  // Monitor: pops expectations whenever the DUT drives the accelerator or a response.
  always begin
    acc_t a;
    rsp_t r;
    @(negedge clock);
    if (armed) begin
      if (acc_wr_en || acc_rd_en) begin
        if (acc_q.size() == 0) flag("acc_unexpected_enable");
        else begin
          a = acc_q.pop_front();
          chk("acc_cycle", 64'(cycle), 64'(a.due));
          chk("acc_addr", 64'(acc_addr), 64'(a.addr));
          chk("acc_wr_en", 64'(acc_wr_en), 64'(a.wr));
          chk("acc_rd_en", 64'(acc_rd_en), 64'(!a.wr));
          if (a.wr) chk("acc_dataIn", 64'(acc_dataIn), 64'(a.wdata));
        end
      end else if (acc_q.size() > 0 && acc_q[0].due <= cycle) begin
        flag("acc_missing_enable");
        void'(acc_q.pop_front());
      end
      if (bus.rsp_valid != '0) begin
        if (rsp_q.size() == 0) flag("rsp_unexpected");
        else begin
          r = rsp_q.pop_front();
          chk("rsp_cycle", 64'(cycle), 64'(r.due));
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(1) << r.id);
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
          last_rdata = bus.rsp_rdata;
          $display("[TB] cycle %0d rsp id=%0d rdata=0x%08h", cycle, r.id, bus.rsp_rdata);
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cycle) begin
        flag("rsp_missing");
        void'(rsp_q.pop_front());
      end
    end
  end

  task automatic drive(input int id, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_wr[id]               = wr;
    bus.req_addr[id*AW +: AW]    = addr;
    bus.req_wdata[id*DW +: DW]   = data;
    bus.req_valid[id]            = 1'b1;
  endtask

  // Returns the cycle req_ready[id] was seen; leaves time at posedge+1 of the following cycle.
  task automatic wait_grant(input int id, output int c);
    bit got = 0;
    c = -1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clock);
      if (bus.req_ready[id]) begin
        got = 1;
        c   = cycle;
      end
    end
    if (!got) flag($sformatf("grant_timeout_req%0d", id));
    @(posedge clock);
    #1 bus.req_valid[id] = 1'b0;
  endtask

  task automatic do_txn(input int id, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int c;
    drive(id, wr, addr, data);
    wait_grant(id, c);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_acc_addr"}, 64'(acc_addr), 64'd0);
    chk({tag, "_acc_rd_en"}, 64'(acc_rd_en), 64'd0);
    chk({tag, "_acc_wr_en"}, 64'(acc_wr_en), 64'd0);
    chk({tag, "_acc_dataIn"}, 64'(acc_dataIn), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  initial begin
    int c0, c1, prev;
    int order[5];
    logic [N-1:0] took;
    order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_outputs_zero("reset");
    @(posedge clock);
    #1;

    // Write then bit-reverse read
    do_txn(0, 1'b1, 2'd0, 32'h0000_0001);
    do_txn(0, 1'b0, 2'd0, 32'h0);
    chk("bitrev_read", 64'(last_rdata), 64'h8000_0000);

    // Increment and inverse reads
    do_txn(1, 1'b1, 2'd0, 32'h0000_000F);
    do_txn(1, 1'b1, 2'd1, 32'h0);
    do_txn(1, 1'b0, 2'd1, 32'h0);
    chk("inc_read", 64'(last_rdata), 64'h0000_0010);
    do_txn(1, 1'b0, 2'd2, 32'h0);
    chk("inv_read", 64'(last_rdata), 64'hFFFF_FFEF);

    // Contention after reset
    pulse_reset();
    drive(0, 1'b0, 2'd1, 32'h0);
    drive(1, 1'b0, 2'd0, 32'h0);
    wait_grant(0, c0);
    wait_grant(1, c1);
    chk("contention_gap", 64'(c1 - c0), 64'd3);
    repeat (2) @(posedge clock);
    #1;

    // Rotation with all four requesters continuously valid
    for (int i = 0; i < N; i++) drive(i, 1'b0, AW'(i % 3), 32'h0);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(order[k], c0);
      if (k == 0) drive(0, 1'b0, 2'd2, 32'h0);
      else chk($sformatf("rotation_gap_%0d", k), 64'(c0 - prev), 64'd3);
      prev = c0;
    end
    repeat (2) @(posedge clock);
    #1;

    // Reset while a read of addr2 sits in ISSUE
    do_txn(1, 1'b0, 2'd1, 32'h0);
    drive(2, 1'b0, 2'd2, 32'h0);
    wait_grant(2, c0);
    pulse_reset();
    @(negedge clock);
    chk_outputs_zero("midreset");
    @(posedge clock);
    #1;
    drive(3, 1'b0, 2'd2, 32'h0);
    drive(1, 1'b0, 2'd2, 32'h0);
    wait_grant(1, c0);
    wait_grant(3, c1);
    chk("post_reset_gap", 64'(c1 - c0), 64'd3);
    repeat (2) @(posedge clock);
    #1;

    // Addr3 read returns zero; busy lasts two cycles
    drive(0, 1'b0, 2'd3, 32'h0);
    wait_grant(0, c0);
    @(negedge clock);
    chk("addr3_busy_issue", 64'(busy), 64'd1);
    @(negedge clock);
    chk("addr3_busy_resp", 64'(busy), 64'd1);
    @(negedge clock);
    chk("addr3_busy_idle", 64'(busy), 64'd0);
    chk("addr3_read", 64'(last_rdata), 64'd0);
    @(posedge clock);
    #1;

    // Randomised traffic, including early drops of req_valid
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      took = bus.req_valid & bus.req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (took[i]) bus.req_valid[i] = 1'b0;
        else if (!bus.req_valid[i] && $urandom_range(3) == 0)
          drive(i, 1'($urandom_range(1)), AW'($urandom_range(3)), $urandom);
        else if (bus.req_valid[i] && $urandom_range(19) == 0)
          bus.req_valid[i] = 1'b0;
      end
    end
    @(negedge clock);
    @(posedge clock);
    #1 bus.req_valid = '0;
    repeat (8) @(posedge clock);
    #1;
    chk("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
    chk("drain_acc_q", 64'(acc_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dp_arbiter.md
Name: dp_arbiter

Overview:
Round-robin arbiter that shares one dp_accelerator register port among NUM_REQ requesters. Each requester issues single-beat read/write commands through a valid/ready handshake. The arbiter serialises the commands onto the accelerator's addr/rd_en/wr_en/dataIn/dataOut port and returns a one-cycle response to the winning requester. It sits between the requester masters and the accelerator slave.

Parameters:
NUM_REQ, 2, number of requesters (legal range 2..8)
DATA_W, 32, data width; must match the accelerator
ADDR_W, 2, accelerator register address width
PTR_W, $clog2(NUM_REQ), round-robin pointer width (derived; not overridden)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  one-hot accept strobe for the winning requester
req_wr  in  NUM_REQ  per-requester command type: 1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed per-requester register address; requester i uses bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed per-requester write data
rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
rsp_rdata  out  DATA_W  shared response data; qualified by rsp_valid
acc_addr  out  ADDR_W  accelerator address
acc_rd_en  out  1  accelerator read enable
acc_wr_en  out  1  accelerator write enable
acc_dataIn  out  DATA_W  accelerator write data
acc_dataOut  in  DATA_W  accelerator read data (combinational from acc_addr/acc_rd_en)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous and active-high; one clock domain (clock).
- On reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, rsp_valid, rsp_rdata, acc_*, busy).
- FSM states IDLE -> ISSUE -> RESP -> IDLE. Fixed 3-cycle transaction; at most one transaction in flight.
- IDLE:
  - If any req_valid is set, pick the winner: the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[winner] is asserted combinationally in the same cycle; valid & ready is the handshake.
  - At that edge latch cmd_wr, cmd_addr, cmd_wdata and cmd_id=winner, then go to ISSUE.
  - With no req_valid, remain in IDLE. All req_ready are 0 outside IDLE.
- ISSUE:
  - Registered outputs: acc_addr=cmd_addr, acc_dataIn=cmd_wdata; acc_wr_en=cmd_wr; acc_rd_en=~cmd_wr. Enables are high for exactly this one cycle.
  - For a read, capture acc_dataOut into rsp_rdata at the ISSUE->RESP edge. For a write, rsp_rdata=0.
  - Then go to RESP.
- RESP:
  - rsp_valid[cmd_id]=1 for exactly one cycle; acc enables are 0.
  - rr_ptr <= (cmd_id+1) mod NUM_REQ; go to IDLE.
  - rsp_rdata holds its value until the next capture.
- Request rules:
  - Requesters must hold req_valid and their payload stable until req_ready.
  - Dropping req_valid before acceptance is legal, and no transaction results.
- Fairness: a continuously requesting set of N masters is granted in strict rotation. Worst-case wait is (NUM_REQ-1) transactions = 3*(NUM_REQ-1) cycles.
- Pass-through:
  - Addresses 2 and 3 for writes are issued unchanged; the accelerator ignores them, and the arbiter still acks.
  - A read of address 3 returns whatever the accelerator drives (0).
- Reset mid-transaction (in ISSUE or RESP): the next cycle is IDLE with all outputs 0. No rsp_valid is emitted and the pending command is dropped; the requester must reissue.
- Peak throughput: one transaction per 3 cycles (IDLE accept, ISSUE, RESP). A back-to-back request is accepted in the IDLE cycle after RESP.

Decomposition:
- Package dp_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - accelerator register map constants: ADDR_BITREV=2'b00, ADDR_INC_RAW=2'b01, ADDR_INV=2'b10;
  - DATA_W / ADDR_W defaults.
- Sub-module rr_picker (combinational): inputs req vector and rr_ptr; outputs one-hot grant and encoded winner index. It is reusable by other shared-resource arbiters.

Test Plan:
- Write then bit-reverse read: req0 writes addr0 data 0x00000001, then reads addr0 -> rsp_valid[0] pulse with rsp_rdata=0x80000000. acc_wr_en and acc_rd_en are each high exactly 1 cycle.
- Increment and inverse reads: req1 writes addr0 0x0000000F, writes addr1 (increment), then reads addr1 -> 0x00000010; reads addr2 -> 0xFFFFFFEF.
- Contention: after reset, req0 and req1 are valid in the same cycle -> req_ready[0] first; req1 is granted in the IDLE cycle after req0's RESP, i.e. 3 cycles later.
- Rotation with NUM_REQ=4: all four requesters valid continuously -> grant order 0,1,2,3,0; each rsp_valid arrives 2 cycles after its req_ready.
- Reset in ISSUE: assert reset for 1 cycle while a read to addr2 is in flight -> no rsp_valid, outputs 0, rr_ptr=0. A subsequent request completes normally.
- Addr3 read: req0 reads addr3 -> rsp_rdata=0x00000000, and busy is high for exactly 2 cycles after acceptance.
